// File: rtl/imem_loader.sv
// Serial instruction-memory loader: receives a length-prefixed, checksummed
// byte stream, writes it to IMEM as 32-bit words and releases the processor.
module imem_loader #(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              SYS_clk,
   input  logic              SYS_reset,
   input  logic              SYS_load,
   input  logic [31:0]       SYS_pc_val,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_waddr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_hold,
   output logic              pc_load,
   output logic [31:0]       pc_init,
   output logic              load_busy,
   output logic              load_err,
   output logic [ADDR_W:0]   words_loaded
);

   localparam int unsigned CNT_W    = ADDR_W + 1;
   localparam logic [31:0] CAPACITY = 32'(1) << ADDR_W;

   typedef enum logic [2:0] {
      IDLE,
      LEN0,
      LEN1,
      DATA,
      CHK,
      DONE,
      ERR
   } state_t;

   state_t state, state_d;

   logic [7:0]        len_lo, len_lo_d;
   logic [15:0]       len, len_d;
   logic [15:0]       len_next;
   logic [1:0]        byte_idx, byte_idx_d;
   logic [23:0]       word_buf, word_buf_d;
   logic [7:0]        csum, csum_d;
   logic              accept;

   logic              rx_ready_d;
   logic              imem_we_d;
   logic [ADDR_W-1:0] imem_waddr_d;
   logic [31:0]       imem_wdata_d;
   logic              cpu_hold_d;
   logic              pc_load_d;
   logic [31:0]       pc_init_d;
   logic              load_busy_d;
   logic              load_err_d;
   logic [CNT_W-1:0]  words_loaded_d;

   // rx_ready is registered from the next state, so it always reflects the current state
   assign accept   = rx_valid & rx_ready;
   assign len_next = {rx_data, len_lo};

   // State register
   always_ff @(posedge SYS_clk) begin
      if (SYS_reset) state <= IDLE;
      else           state <= state_d;
   end

   // Next-state, datapath and next-output logic
   always_comb begin
      state_d        = state;
      len_lo_d       = len_lo;
      len_d          = len;
      byte_idx_d     = byte_idx;
      word_buf_d     = word_buf;
      csum_d         = csum;
      pc_init_d      = pc_init;
      load_err_d     = load_err;
      words_loaded_d = words_loaded;
      imem_we_d      = 1'b0;
      imem_waddr_d   = imem_waddr;
      imem_wdata_d   = imem_wdata;

      case (state)
         IDLE, ERR: begin
            if (SYS_load) begin
               state_d        = LEN0;
               pc_init_d      = SYS_pc_val;
               load_err_d     = 1'b0;
               words_loaded_d = '0;
               byte_idx_d     = '0;
               csum_d         = '0;
               word_buf_d     = '0;
            end
         end
         LEN0: begin
            if (accept) begin
               len_lo_d = rx_data;
               state_d  = LEN1;
            end
         end
         LEN1: begin
            if (accept) begin
               len_d = len_next;
               if ((len_next == 16'd0) || (32'(len_next) > CAPACITY)) begin
                  state_d    = ERR;
                  load_err_d = 1'b1;
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (accept) begin
               csum_d     = csum ^ rx_data;
               byte_idx_d = byte_idx + 2'd1;
               case (byte_idx)
                  2'd0: word_buf_d[7:0]   = rx_data;
                  2'd1: word_buf_d[15:8]  = rx_data;
                  2'd2: word_buf_d[23:16] = rx_data;
                  default: begin
                     // Fourth byte completes the word; the write issues next cycle
                     imem_we_d      = 1'b1;
                     imem_waddr_d   = words_loaded[ADDR_W-1:0];
                     imem_wdata_d   = {rx_data, word_buf};
                     words_loaded_d = words_loaded + CNT_W'(1);
                     if ((32'(words_loaded) + 32'd1) == 32'(len)) state_d = CHK;
                  end
               endcase
            end
         end
         CHK: begin
            if (accept) begin
               if (rx_data == csum) begin
                  state_d = DONE;
               end else begin
                  state_d    = ERR;
                  load_err_d = 1'b1;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      rx_ready_d  = (state_d == LEN0) || (state_d == LEN1) ||
                    (state_d == DATA) || (state_d == CHK);
      load_busy_d = rx_ready_d;
      cpu_hold_d  = (state_d != IDLE);
      pc_load_d   = (state_d == DONE);
   end

   // Datapath and output registers
   always_ff @(posedge SYS_clk) begin
      if (SYS_reset) begin
         len_lo       <= '0;
         len          <= '0;
         byte_idx     <= '0;
         word_buf     <= '0;
         csum         <= '0;
         rx_ready     <= 1'b0;
         imem_we      <= 1'b0;
         imem_waddr   <= '0;
         imem_wdata   <= '0;
         cpu_hold     <= 1'b0;
         pc_load      <= 1'b0;
         pc_init      <= '0;
         load_busy    <= 1'b0;
         load_err     <= 1'b0;
         words_loaded <= '0;
      end else begin
         len_lo       <= len_lo_d;
         len          <= len_d;
         byte_idx     <= byte_idx_d;
         word_buf     <= word_buf_d;
         csum         <= csum_d;
         rx_ready     <= rx_ready_d;
         imem_we      <= imem_we_d;
         imem_waddr   <= imem_waddr_d;
         imem_wdata   <= imem_wdata_d;
         cpu_hold     <= cpu_hold_d;
         pc_load      <= pc_load_d;
         pc_init      <= pc_init_d;
         load_busy    <= load_busy_d;
         load_err     <= load_err_d;
         words_loaded <= words_loaded_d;
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table vectors, hand sequences for
// reset/stall corners, and randomized sessions against a stream-level model.
module tb_imem_loader;

   localparam int unsigned ADDR_W = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              load = 1'b0;
   logic [31:0]       pc_val = '0;
   logic [7:0]        rx_data = '0;
   logic              rx_valid = 1'b0;
   logic              rx_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_waddr;
   logic [31:0]       imem_wdata;
   logic              cpu_hold;
   logic              pc_load;
   logic [31:0]       pc_init;
   logic              load_busy;
   logic              load_err;
   logic [ADDR_W:0]   words_loaded;

   imem_loader #(.ADDR_W(ADDR_W)) dut (
      .SYS_clk      (clk),
      .SYS_reset    (rst),
      .SYS_load     (load),
      .SYS_pc_val   (pc_val),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .imem_we      (imem_we),
      .imem_waddr   (imem_waddr),
      .imem_wdata   (imem_wdata),
      .cpu_hold     (cpu_hold),
      .pc_load      (pc_load),
      .pc_init      (pc_init),
      .load_busy    (load_busy),
      .load_err     (load_err),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // Observed IMEM writes and pc_load pulses
   logic [ADDR_W-1:0] wr_addr_q[$];
   logic [31:0]       wr_data_q[$];
   int                pcl_cnt = 0;
   logic [31:0]       pcl_pc  = '0;

   // Expected IMEM contents for the current session (address = index)
   logic [31:0]       exp_data_q[$];

   typedef struct {
      logic [31:0]  pc;
      int           nbytes;
      logic [127:0] stream;    // bytes in send order, first byte in bits [127:120]
      int           exp_writes;
      logic [31:0]  exp_w0;
      logic [31:0]  exp_w1;
      bit           exp_err;
      bit           exp_pcl;
   } vec_t;

   vec_t vecs[5];

   // Record DUT output events away from the active edge
   always @(negedge clk) begin
      if (imem_we) begin
         wr_addr_q.push_back(imem_waddr);
         wr_data_q.push_back(imem_wdata);
      end
      if (pc_load) begin
         pcl_cnt++;
         pcl_pc = pc_init;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual %0h required %0h", name, act, exp);
   endtask

   task automatic clear_obs();
      wr_addr_q.delete();
      wr_data_q.delete();
      pcl_cnt = 0;
      pcl_pc  = '0;
   endtask

   // Called and returns at a falling edge
   task automatic send_byte(input logic [7:0] b, input bit stall);
      int guard = 0;
      if (stall) begin
         for (int k = 0; k < 4 && $urandom_range(0, 1) == 1; k++) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            @(negedge clk);
         end
      end
      rx_valid = 1'b1;
      rx_data  = b;
      while (!rx_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) chk("rx_ready_timeout", 64'd1, 64'd0);
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
   endtask

   task automatic pulse_load(input logic [31:0] pc);
      load   = 1'b1;
      pc_val = pc;
      @(negedge clk);
      load   = 1'b0;
      pc_val = 32'($urandom);
   endtask

   // Start a session and push the stream; optionally inject a stray SYS_load before byte extra_at
   task automatic run_stream(input string tag, input logic [31:0] pc, input logic [7:0] bs[$],
                             input bit stall, input int extra_at);
      clear_obs();
      pulse_load(pc);
      chk({tag, ".err_cleared"}, 64'(load_err), 64'd0);
      chk({tag, ".busy_at_start"}, 64'(load_busy), 64'd1);
      for (int i = 0; i < bs.size(); i++) begin
         if (i == extra_at) begin
            load   = 1'b1;
            pc_val = ~pc;
            @(negedge clk);
            load   = 1'b0;
         end
         send_byte(bs[i], stall);
      end
      repeat (4) @(negedge clk);
   endtask

   // Stream-level reference: parse length, pack words, XOR checksum
   task automatic model(input logic [7:0] bs[$], output bit err, output bit pcl);
      int unsigned n;
      logic [7:0]  x;
      exp_data_q.delete();
      n = {bs[1], bs[0]};
      if (n == 0 || n > (1 << ADDR_W)) begin
         err = 1'b1;
         pcl = 1'b0;
         return;
      end
      x = 8'h00;
      for (int unsigned w = 0; w < n; w++) begin
         logic [31:0] word;
         for (int unsigned k = 0; k < 4; k++) begin
            word[8*k +: 8] = bs[2 + 4*w + k];
            x = x ^ bs[2 + 4*w + k];
         end
         exp_data_q.push_back(word);
      end
      err = (bs[2 + 4*n] != x);
      pcl = !err;
   endtask

   task automatic compare(input string tag, input logic [31:0] pc, input bit e_err, input bit e_pcl);
      int nw;
      chk({tag, ".nwrites"}, 64'(wr_data_q.size()), 64'(exp_data_q.size()));
      nw = (wr_data_q.size() < exp_data_q.size()) ? wr_data_q.size() : exp_data_q.size();
      for (int i = 0; i < nw; i++) begin
         chk($sformatf("%s.waddr%0d", tag, i), 64'(wr_addr_q[i]), 64'(i));
         chk($sformatf("%s.wdata%0d", tag, i), 64'(wr_data_q[i]), 64'(exp_data_q[i]));
      end
      chk({tag, ".words_loaded"}, 64'(words_loaded), 64'(exp_data_q.size()));
      chk({tag, ".load_err"}, 64'(load_err), 64'(e_err));
      chk({tag, ".pc_load_cnt"}, 64'(pcl_cnt), e_pcl ? 64'd1 : 64'd0);
      if (e_pcl) chk({tag, ".pc_at_pcload"}, 64'(pcl_pc), 64'(pc));
      chk({tag, ".pc_init"}, 64'(pc_init), 64'(pc));
      chk({tag, ".cpu_hold"}, 64'(cpu_hold), 64'(e_err));
      chk({tag, ".load_busy"}, 64'(load_busy), 64'd0);
      chk({tag, ".rx_ready"}, 64'(rx_ready), 64'd0);
   endtask

   initial begin
      logic [7:0]  bs[$];
      bit          m_err, m_pcl;
      logic [31:0] pc;
      logic [7:0]  x;
      int          n;

      vecs[0] = '{32'h0040_0000, 11, {88'h02_00_78_56_34_12_EF_BE_AD_DE_2A, 40'h0},
                  2, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0, 1'b1};
      vecs[1] = '{32'h0040_0000, 11, {88'h02_00_78_56_34_12_EF_BE_AD_DE_2B, 40'h0},
                  2, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1, 1'b0};
      vecs[2] = '{32'h0000_2000, 2, {16'h01_01, 112'h0},
                  0, 32'h0, 32'h0, 1'b1, 1'b0};
      vecs[3] = '{32'h0000_3000, 2, {16'h00_00, 112'h0},
                  0, 32'h0, 32'h0, 1'b1, 1'b0};
      vecs[4] = '{32'h0000_1000, 7, {56'h01_00_11_22_33_44_44, 72'h0},
                  1, 32'h4433_2211, 32'h0, 1'b0, 1'b1};

      // Reset: every output low
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst.outputs", 64'({rx_ready, imem_we, imem_waddr, cpu_hold, pc_load, load_busy,
                              load_err, words_loaded}), 64'd0);
      chk("rst.wdata", 64'(imem_wdata), 64'd0);
      chk("rst.pc_init", 64'(pc_init), 64'd0);

      // Bytes offered in IDLE are not accepted
      clear_obs();
      rx_valid = 1'b1;
      rx_data  = 8'hAA;
      repeat (3) @(negedge clk);
      rx_valid = 1'b0;
      chk("idle.rx_ready", 64'(rx_ready), 64'd0);
      chk("idle.busy", 64'(load_busy), 64'd0);
      chk("idle.nwrites", 64'(wr_data_q.size()), 64'd0);

      // Table vectors
      foreach (vecs[v]) begin
         bs.delete();
         for (int i = 0; i < vecs[v].nbytes; i++) bs.push_back(vecs[v].stream[127 - 8*i -: 8]);
         exp_data_q.delete();
         if (vecs[v].exp_writes >= 1) exp_data_q.push_back(vecs[v].exp_w0);
         if (vecs[v].exp_writes >= 2) exp_data_q.push_back(vecs[v].exp_w1);
         run_stream($sformatf("vec%0d", v), vecs[v].pc, bs, 1'b0, -1);
         compare($sformatf("vec%0d", v), vecs[v].pc, vecs[v].exp_err, vecs[v].exp_pcl);
      end

      // Stalled delivery with a stray SYS_load in DATA
      bs.delete();
      for (int i = 0; i < 11; i++) bs.push_back(vecs[0].stream[127 - 8*i -: 8]);
      model(bs, m_err, m_pcl);
      run_stream("stall_load", 32'h0040_0000, bs, 1'b1, 6);
      compare("stall_load", 32'h0040_0000, m_err, m_pcl);

      // Randomized sessions
      for (int s = 0; s < 8; s++) begin
         n = (s == 7) ? (1 << ADDR_W) : int'($urandom_range(1, 8));
         pc = 32'($urandom);
         bs.delete();
         bs.push_back(8'(n));
         bs.push_back(8'(n >> 8));
         x = 8'h00;
         for (int i = 0; i < 4*n; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            bs.push_back(b);
            x = x ^ b;
         end
         if (s != 7 && $urandom_range(0, 3) == 0) x = x ^ 8'(1 << $urandom_range(0, 7));
         bs.push_back(x);
         model(bs, m_err, m_pcl);
         run_stream($sformatf("rand%0d", s), pc, bs, (s != 7), (s == 2) ? 8 : -1);
         compare($sformatf("rand%0d", s), pc, m_err, m_pcl);
      end

      // Reset after five data bytes
      clear_obs();
      pulse_load(32'h0040_0000);
      bs.delete();
      for (int i = 0; i < 7; i++) bs.push_back(vecs[0].stream[127 - 8*i -: 8]);
      foreach (bs[i]) send_byte(bs[i], 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("midrst.nwrites", 64'(wr_data_q.size()), 64'd1);
      if (wr_data_q.size() > 0) chk("midrst.wdata0", 64'(wr_data_q[0]), 64'h1234_5678);
      chk("midrst.words_loaded", 64'(words_loaded), 64'd0);
      chk("midrst.cpu_hold", 64'(cpu_hold), 64'd0);
      chk("midrst.pc_load_cnt", 64'(pcl_cnt), 64'd0);
      chk("midrst.busy", 64'(load_busy), 64'd0);
      chk("midrst.rx_ready", 64'(rx_ready), 64'd0);
      chk("midrst.pc_init", 64'(pc_init), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
